// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM plus memory-mapped IO behind the CPU memory bus.
// IO window is mem_a[17:16] == 2'b11:
//   0x30000 write -> push byte into TX FIFO (dropped and flagged when full)
//   0x30000 read  -> RX byte (pops it) or 0 when nothing is pending
//   0x30004 read  -> {6'b0, io_buffer_full, tx_valid}
//   0x30004 write -> simulation halt request
// Optional feature macro: MEM_RESPONDER_SIM_HALT_EN. When defined, a write to
// 0x30004 latches halt and the exit code. Once the TX FIFO has drained, the
// exit code is printed and the simulation finishes. When undefined, halt is 0.
module mem_responder #(
  parameter int ADDR_WIDTH    = 17,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int CW    = TX_DEPTH_LOG2 + 1;

  // Address decode
  logic is_io;
  logic io_data_sel;
  logic io_stat_sel;
  assign is_io       = (mem_a[17:16] == 2'b11);
  assign io_data_sel = is_io && (mem_a[15:0] == 16'h0000);
  assign io_stat_sel = is_io && (mem_a[15:0] == 16'h0004);

  // Address bits above the decoded window have no effect on this block
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_a[31:18];

  // RAM storage (no reset: contents survive rst)
  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  assign ram_idx = mem_a[ADDR_WIDTH-1:0];
  assign ram_we  = mem_wr && !is_io;

  // TX FIFO state. The pointers wrap modulo the depth by their width; count
  // carries one extra bit so that "full" (count == DEPTH) is representable.
  logic [7:0]               tx_mem [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]            count;
  logic [CW-1:0]            free_slots;
  logic                     overflow_sticky;
  logic                     fifo_full;
  logic                     tx_push;
  logic                     tx_pop;
  logic                     tx_accept;

  assign fifo_full  = (count == CW'(DEPTH));
  assign free_slots = CW'(DEPTH) - count;
  assign tx_valid   = (count != '0);
  assign tx_data    = tx_mem[rd_ptr];
  // The margin absorbs the store byte already in flight when the flag rises
  assign io_buffer_full = (free_slots <= CW'(FULL_MARGIN));

  assign tx_push   = mem_wr && io_data_sel;
  assign tx_pop    = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives
  assign tx_accept = tx_push && (!fifo_full || tx_pop);

  // IO read data mux, sampled into mem_din at the read edge
  logic [7:0] io_rd_data;
  logic       rx_take;
  logic       mem_din_reg;
  assign rx_take = !mem_wr && io_data_sel && rx_valid;

  // Select the IO register read value; unmapped IO reads return zero
  always_comb begin
    io_rd_data = 8'h00;
    if (io_data_sel && rx_valid) begin
      io_rd_data = rx_data;
    end else if (io_stat_sel) begin
      io_rd_data = {6'b0, io_buffer_full, tx_valid};
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  // Registered read data; holds its value during write cycles
  logic [7:0] rd_data_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg <= 8'h00;
    end else if (!mem_wr) begin
      rd_data_reg <= is_io ? io_rd_data : ram[ram_idx];
    end
  end
  assign mem_din     = rd_data_reg;
  assign mem_din_reg = 1'b0;

  // RX consume pulse, one cycle after the read edge
  logic rx_pop_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pop_reg <= 1'b0;
    end else begin
      rx_pop_reg <= rx_take;
    end
  end
  assign rx_pop = rx_pop_reg;

  // TX FIFO storage write
  always_ff @(posedge clk) begin
    if (tx_accept) begin
      tx_mem[wr_ptr] <= mem_dout;
    end
  end

  // TX FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      if (tx_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(tx_accept) - CW'(tx_pop);
      if (tx_push && !tx_accept) begin
        overflow_sticky <= 1'b1;
      end
    end
  end

  logic unused_misc;
  assign unused_misc = mem_din_reg;

`ifdef MEM_RESPONDER_SIM_HALT_EN
  logic       halt_wr;
  logic       halt_reg;
  logic [7:0] exit_code_reg;
  assign halt_wr = mem_wr && io_stat_sel;

  // Latch the halt request and its exit code until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_reg      <= 1'b0;
      exit_code_reg <= 8'h00;
    end else if (halt_wr && !halt_reg) begin
      halt_reg      <= 1'b1;
      exit_code_reg <= mem_dout;
    end
  end
  assign halt = halt_reg;

  // End the simulation once every queued TX byte has left
  always_ff @(posedge clk) begin
    if (!rst && halt_reg && (count == '0)) begin
      $display("mem_responder: halt requested, exit code %0d", exit_code_reg);
      $finish;
    end
  end
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus a random phase, checked
// by a scoreboard against a queue/array reference model of the bus behaviour.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halt;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_pop(rx_pop), .halt(halt)
  );

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  typedef struct {
    logic [7:0] din;
    logic       rxp;
    logic       tv;
    logic       full;
    logic       ovf;
  } exp_t;

  // Reference model state
  logic [7:0] ram_m [logic [16:0]];
  logic [7:0] txm [$];
  logic [7:0] tx_exp [$];
  logic       ovf_m = 1'b0;
  logic [7:0] din_m = 8'h00;
  exp_t       exp_q [$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // One bus cycle: drive inputs, advance the model to the upcoming edge,
  // then hand the post-edge expectation to the monitor.
  task automatic cycle(input logic r, input logic wr, input logic [31:0] a,
                       input logic [7:0] d, input logic rdy,
                       input logic rxv, input logic [7:0] rxd);
    exp_t e;
    bit   io;
    int   sz;
    rst = r; mem_wr = wr; mem_a = a; mem_dout = d;
    tx_ready = rdy; rx_valid = rxv; rx_data = rxd;
    e.rxp = 1'b0;
    if (r) begin
      txm.delete();
      tx_exp.delete();
      ovf_m = 1'b0;
      din_m = 8'h00;
    end else begin
      io = (a[17:16] == 2'b11);
      sz = txm.size();
      if (!wr) begin
        if (!io) begin
          din_m = ram_m.exists(a[16:0]) ? ram_m[a[16:0]] : 8'h00;
        end else if (a[15:0] == 16'h0000) begin
          din_m = rxv ? rxd : 8'h00;
          e.rxp = rxv;
        end else if (a[15:0] == 16'h0004) begin
          din_m = {6'b0, ((DEPTH - sz) <= MARGIN), (sz > 0)};
        end else begin
          din_m = 8'h00;
        end
      end else if (!io) begin
        ram_m[a[16:0]] = d;
      end
      if (sz > 0 && rdy) void'(txm.pop_front());
      if (wr && io && a[15:0] == 16'h0000) begin
        if (txm.size() < DEPTH) begin
          txm.push_back(d);
          tx_exp.push_back(d);
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    e.din  = din_m;
    e.tv   = (txm.size() > 0);
    e.full = ((DEPTH - txm.size()) <= MARGIN);
    e.ovf  = ovf_m;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compare outputs on the falling edge after each bus cycle
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("mem_din", {24'b0, mem_din}, {24'b0, mon_e.din});
      check("rx_pop", {31'b0, rx_pop}, {31'b0, mon_e.rxp});
      check("tx_valid", {31'b0, tx_valid}, {31'b0, mon_e.tv});
      check("io_buffer_full", {31'b0, io_buffer_full}, {31'b0, mon_e.full});
      check("overflow_sticky", {31'b0, dut.overflow_sticky}, {31'b0, mon_e.ovf});
      check("halt", {31'b0, halt}, 32'd0);
    end
    if (!rst && tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) begin
        check("tx_unexpected_byte", 32'd1, 32'd0);
      end else begin
        check("tx_data", {24'b0, tx_data}, {24'b0, tx_exp.pop_front()});
      end
    end
  end

  localparam logic [31:0] IO_DATA  = 32'h0003_0000;
  localparam logic [31:0] IO_STAT  = 32'h0003_0004;
  localparam logic [31:0] IO_OTHER = 32'h0003_0008;

  initial begin
    rst = 1'b1; mem_wr = 1'b0; mem_a = 32'h0; mem_dout = 8'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;

    // Reset
    cycle(1, 0, 32'h0, 8'h0, 0, 0, 8'h0);
    cycle(1, 0, 32'h0, 8'h0, 0, 0, 8'h0);

    // RAM write then read-after-write
    cycle(0, 1, 32'h0000_0010, 8'hA5, 0, 0, 8'h0);
    cycle(0, 0, 32'h0000_0010, 8'h00, 0, 0, 8'h0);

    // Streaming read
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h100 + i, 8'(8'h11 * (i + 1)), 0, 0, 8'h0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 32'h100 + i, 8'h00, 0, 0, 8'h0);

    // TX fill to the margin, to full, then one dropped push
    for (int i = 1; i <= 17; i++) cycle(0, 1, IO_DATA, 8'(i), 0, 0, 8'h0);
    cycle(0, 0, IO_STAT, 8'h00, 0, 0, 8'h0);
    check("count_after_fill", {27'b0, dut.count}, 32'd16);
    check("overflow_after_17th", {31'b0, dut.overflow_sticky}, 32'd1);

    // Drain down to 5 queued bytes, then push while draining across the wrap
    for (int i = 0; i < 11; i++) cycle(0, 0, 32'h10, 8'h00, 1, 0, 8'h0);
    for (int i = 0; i < 20; i++) cycle(0, 1, IO_DATA, 8'(8'h40 + i), 1, 0, 8'h0);
    check("count_steady", {27'b0, dut.count}, 32'd5);

    // RX read with and without a pending byte
    cycle(0, 0, IO_DATA, 8'h00, 1, 1, 8'h5A);
    cycle(0, 0, IO_DATA, 8'h00, 1, 0, 8'h5A);
    cycle(0, 0, IO_OTHER, 8'h00, 1, 0, 8'h00);

    // Reset mid-operation with queued bytes; RAM survives
    for (int i = 0; i < 3; i++) cycle(0, 1, IO_DATA, 8'(8'hC0 + i), 0, 0, 8'h0);
    cycle(1, 0, 32'h0, 8'h00, 0, 0, 8'h0);
    cycle(0, 0, 32'h0000_0010, 8'h00, 0, 0, 8'h0);
    cycle(0, 0, IO_OTHER, 8'h00, 0, 0, 8'h0);

    // Preload a RAM pool for random reads
    for (int i = 0; i < 64; i++) cycle(0, 1, 32'(i), 8'($urandom), 0, 0, 8'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      int          op;
      logic        rdy;
      op  = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 2) != 0);
      ra  = {14'($urandom), 1'($urandom), 11'b0, 6'($urandom)};
      if (op < 20)      cycle(0, 1, ra, 8'($urandom), rdy, 0, 8'h0);
      else if (op < 45) cycle(0, 0, ra, 8'h00, rdy, 0, 8'h0);
      else if (op < 70) cycle(0, 1, IO_DATA, 8'($urandom), rdy, 0, 8'h0);
      else if (op < 78) cycle(0, 0, IO_STAT, 8'h00, rdy, 0, 8'h0);
      else if (op < 88) cycle(0, 0, IO_DATA, 8'h00, rdy, 1'($urandom), 8'($urandom));
      else if (op < 92) cycle(0, 1, IO_OTHER, 8'($urandom), rdy, 0, 8'h0);
      else if (op < 95) cycle(0, 0, IO_OTHER, 8'h00, rdy, 1, 8'($urandom));
      else if (op < 98) cycle(0, 1, IO_STAT, 8'($urandom), rdy, 0, 8'h0);
      else              cycle(1, 0, 32'h0, 8'h00, rdy, 0, 8'h0);
    end

    // Drain whatever is left
    for (int i = 0; i < 40; i++) cycle(0, 0, IO_OTHER, 8'h00, 1, 0, 8'h0);
    @(negedge clk);
    #1;
    check("tx_drained", 32'(tx_exp.size()), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-wide memory/IO responder on the far side of the CPU memory bus. Serves single-byte reads and writes issued by the memory controller each cycle. Decodes the IO window (`mem_a[17:16] == 2'b11`) into a transmit FIFO toward the UART and an RX byte register. Generates the `io_buffer_full` back-pressure the controller checks before each IO store byte.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM holds 2^ADDR_WIDTH bytes, indexed by `mem_a[ADDR_WIDTH-1:0]`.
- `TX_DEPTH_LOG2`, 4: TX FIFO depth = 2^TX_DEPTH_LOG2 entries.
- `FULL_MARGIN`, 2: `io_buffer_full` asserts when free entries are `<= FULL_MARGIN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_a`  in  32  byte address from the controller.
- `mem_wr`  in  1  1 = write `mem_dout` at `mem_a` this cycle; 0 = read.
- `mem_dout`  in  8  write data from the controller.
- `mem_din`  out  8  registered read data to the controller.
- `io_buffer_full`  out  1  TX FIFO near-full, combinational from the occupancy count.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  UART accepts the head byte when `tx_valid && tx_ready`.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_pop`  out  1  one-cycle pulse: RX byte consumed.
- `halt`  out  1  simulation halt request (see Configuration).

## Operation
- Decode: IO when `mem_a[17:16] == 2'b11`, otherwise RAM. Bits above `ADDR_WIDTH` are ignored for RAM.
- RAM write (`mem_wr=1`, non-IO): `ram[mem_a] <= mem_dout` at the posedge.
- RAM read (`mem_wr=0`, non-IO): `mem_din <= ram[mem_a]` at the posedge.
- While `mem_wr=1`, `mem_din` holds its previous value.
- IO write to `0x30000`: push `mem_dout` into the TX FIFO. If the FIFO is already full, the byte is dropped and `overflow_sticky` is set. `overflow_sticky` is internal, visible in simulation, and cleared only by `rst`.
- IO write to `0x30004`: halt request; behaviour is defined under Configuration.
- Other IO writes: ignored.
- IO read at `0x30000`:
  - `rx_valid=1`: `mem_din <= rx_data` and `rx_pop` pulses for one cycle.
  - `rx_valid=0`: `mem_din <= 8'h00`, no pop.
- IO read at `0x30004`: `mem_din <= {6'b0, io_buffer_full, tx_valid}`.
- Other IO reads: return `8'h00`.
- TX FIFO: circular buffer with `wr_ptr`, `rd_ptr` and `count` of width `TX_DEPTH_LOG2+1`.
  - Pointers wrap modulo depth.
  - Pop occurs when `tx_valid && tx_ready`.
- Simultaneous push and pop:
  - Non-full, non-empty FIFO: both happen and `count` is unchanged.
  - Empty FIFO: push only. The new byte is not popped in the same cycle.
  - Full FIFO: pop happens and the push is accepted, so nothing is dropped.
- `io_buffer_full = (2^TX_DEPTH_LOG2 - count) <= FULL_MARGIN`. The margin covers the controller's registered `mem_wr`: one byte already in flight when the flag rises.

## Timing
- Read latency is 1 cycle. The address presented during cycle t is sampled at posedge t. `mem_din` is valid in cycle t+1 and is sampled by the controller at posedge t+1.
- Back-to-back reads at incrementing addresses stream one byte per cycle.
- Write is accepted at the posedge where `mem_wr=1`; no wait states, no acknowledge.
- Read-after-write to the same RAM address in the next cycle returns the new data.
- `tx_valid` and `tx_data` reflect FIFO state after the edge. A pushed byte is visible on `tx_data` one cycle after the write edge.
- `rx_pop` is registered: it is high in the cycle after the read edge.
- Reset (`rst=1` at a posedge):
  - `mem_din=0`, `count=0`, `wr_ptr=rd_ptr=0`, `rx_pop=0`, `halt=0`, `overflow_sticky=0`.
  - Hence `tx_valid=0` and `io_buffer_full=0`.
  - RAM contents are not cleared.
  - Reset mid-stream discards all queued TX bytes.

## Configuration
- Macro: `MEM_RESPONDER_SIM_HALT_EN`.
- Defined:
  - An IO write to `0x30004` sets `halt` (sticky until `rst`).
  - Under simulation, it prints `mem_dout` as the exit code and calls `$finish` once the TX FIFO has drained (`count==0`).
- Undefined: `halt` is tied to 0 and the write to `0x30004` is ignored.

## Test plan
- RAM write then read: write `8'hA5` at `0x00010`, then read `0x00010` in the next cycle → `mem_din==8'hA5` one cycle later.
- Streaming read: preload bytes `0x11,0x22,0x33,0x44` at `0x100..0x103`, present addresses on consecutive cycles → `mem_din` sequence `0x11,0x22,0x33,0x44` at 1-cycle lag.
- TX full margin (depth 16, `tx_ready=0`):
  - Push bytes 1..14 at `0x30000` → `io_buffer_full` rises after the 14th push.
  - Two more pushes succeed, `count==16`.
  - A 17th push is dropped, `overflow_sticky=1`.
- Drain ordering: with 5 bytes queued, hold `tx_ready=1` while pushing one byte per cycle → the output order is preserved across pointer wrap.
- RX read: `rx_valid=1`, `rx_data=8'h5A`, read `0x30000` → `mem_din==8'h5A`, `rx_pop` pulses once. Same read with `rx_valid=0` → `mem_din==0`, no pop.
- Reset mid-operation: queue 3 bytes, assert `rst` → `tx_valid=0`, `io_buffer_full=0`, `mem_din=0`, and RAM byte `0x00010` still reads `8'hA5`.
